// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction fetch over a req/ack handshake,
// and decode of the branch/jump fields consumed by the next-PC logic.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | request outstanding (IMemReq=1) or entry check of CurrentPC
// ISSUE | Instruction valid, waiting for ExecDone without Stall
// FAULT | sticky fetch fault (timeout or misaligned PC), exit by Reset
//
// MAX_WAIT is expected in the range 1..255.  The wait counter is 8 bits wide.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic [31:0] NextPC,
  input  logic        ExecDone,
  input  logic        Stall,
  output logic [31:0] CurrentPC,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [25:0] JumpField,
  output logic [31:0] SignExtImm32,
  output logic        Branch,
  output logic        Jump,
  output logic        FetchFault
);

  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;

  // Last un-acked request cycle before the fetch is declared faulty.
  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } fetchState_t;

  fetchState_t state;
  logic [7:0]  waitCount;

  // The memory always sees the current PC; the request strobe qualifies it.
  assign IMemAddr = CurrentPC;

  // Decode is purely combinational from the latched word, so it follows
  // Instruction exactly, including the all-zero value after reset.
  assign JumpField    = Instruction[25:0];
  assign SignExtImm32 = {{16{Instruction[15]}}, Instruction[15:0]};
  assign Branch       = (Instruction[31:26] == OpBeq);
  assign Jump         = (Instruction[31:26] == OpJ);

  // Fetch/issue sequencing with registered outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= FETCH;
      CurrentPC   <= RESET_PC;
      Instruction <= 32'h0;
      InstrValid  <= 1'b0;
      IMemReq     <= 1'b0;
      FetchFault  <= 1'b0;
      waitCount   <= 8'd0;
    end else begin
      case (state)
        FETCH: begin
          if (!IMemReq) begin
            // Entry cycle: a misaligned PC never reaches the memory.
            if (CurrentPC[1:0] != 2'b00) begin
              state      <= FAULT;
              FetchFault <= 1'b1;
            end else begin
              IMemReq <= 1'b1;
            end
          end else if (IMemAck) begin
            Instruction <= IMemData;
            waitCount   <= 8'd0;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b1;
            state       <= ISSUE;
          end else if (waitCount == WaitLast) begin
            IMemReq    <= 1'b0;
            FetchFault <= 1'b1;
            state      <= FAULT;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end

        ISSUE: begin
          if (ExecDone && !Stall) begin
            CurrentPC  <= NextPC;
            InstrValid <= 1'b0;
            // Request the next word immediately when aligned, giving a
            // two-cycle instruction period; a misaligned PC is caught on
            // the FETCH entry cycle instead.
            IMemReq    <= (NextPC[1:0] == 2'b00);
            state      <= FETCH;
          end
        end

        FAULT: begin
          IMemReq    <= 1'b0;
          InstrValid <= 1'b0;
          FetchFault <= 1'b1;
        end

        default: begin
          IMemReq    <= 1'b0;
          InstrValid <= 1'b0;
          FetchFault <= 1'b1;
          state      <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit (RESET_PC = 0, MAX_WAIT = 4).
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic [31:0] NextPC = 32'h0;
  logic        ExecDone = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] CurrentPC;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [25:0] JumpField;
  logic [31:0] SignExtImm32;
  logic        Branch;
  logic        Jump;
  logic        FetchFault;

  int checks = 0;
  int failures = 0;

  pc_fetch_unit #(
    .RESET_PC(32'h00000000),
    .MAX_WAIT(4)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemAck(IMemAck),
    .IMemData(IMemData),
    .NextPC(NextPC),
    .ExecDone(ExecDone),
    .Stall(Stall),
    .CurrentPC(CurrentPC),
    .Instruction(Instruction),
    .InstrValid(InstrValid),
    .JumpField(JumpField),
    .SignExtImm32(SignExtImm32),
    .Branch(Branch),
    .Jump(Jump),
    .FetchFault(FetchFault)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then settled and inputs may be changed.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    IMemAck  = 1'b1;
    IMemData = 32'hDEADBEEF;
    cycle();
    cycle();
    checks++; if (CurrentPC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", CurrentPC); end
    checks++; if (Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 00000000", Instruction); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", InstrValid); end
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", IMemReq); end
    checks++; if (FetchFault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", FetchFault); end
    checks++; if ({Branch, Jump} !== 2'b00) begin failures++; $display("FAIL reset_decode: got %b expected 00", {Branch, Jump}); end
    checks++; if (JumpField !== 26'h0 || SignExtImm32 !== 32'h0) begin failures++; $display("FAIL reset_fields: got %h/%h expected 0/0", JumpField, SignExtImm32); end
    IMemAck = 1'b0;
    Reset   = 1'b0;
    cycle();
    checks++; if (IMemReq !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", IMemReq); end
    checks++; if (IMemAddr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 00000000", IMemAddr); end
  endtask

  task automatic test_branch();
    IMemAck  = 1'b1;
    IMemData = 32'h10000003;
    cycle();
    IMemAck  = 1'b0;
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL beq_valid: got %b expected 1", InstrValid); end
    checks++; if (Branch !== 1'b1 || Jump !== 1'b0) begin failures++; $display("FAIL beq_decode: got B=%b J=%b expected B=1 J=0", Branch, Jump); end
    checks++; if (SignExtImm32 !== 32'h3) begin failures++; $display("FAIL beq_imm: got %h expected 00000003", SignExtImm32); end
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL beq_req_low: got %b expected 0", IMemReq); end
    ExecDone = 1'b1;
    NextPC   = 32'h10;
    cycle();
    ExecDone = 1'b0;
    checks++; if (CurrentPC !== 32'd16) begin failures++; $display("FAIL beq_commit_pc: got %h expected 00000010", CurrentPC); end
    checks++; if (IMemReq !== 1'b1 || InstrValid !== 1'b0) begin failures++; $display("FAIL beq_refetch: got req=%b valid=%b expected req=1 valid=0", IMemReq, InstrValid); end
  endtask

  task automatic test_jump();
    IMemAck  = 1'b1;
    IMemData = 32'h08000100;
    cycle();
    IMemAck  = 1'b0;
    checks++; if (Jump !== 1'b1 || Branch !== 1'b0) begin failures++; $display("FAIL j_decode: got J=%b B=%b expected J=1 B=0", Jump, Branch); end
    checks++; if (JumpField !== 26'h0000100) begin failures++; $display("FAIL j_field: got %h expected 0000100", JumpField); end
    ExecDone = 1'b1;
    NextPC   = 32'h90000400;
    cycle();
    ExecDone = 1'b0;
    checks++; if (IMemAddr !== 32'h90000400 || IMemReq !== 1'b1) begin failures++; $display("FAIL j_target: got addr=%h req=%b expected 90000400/1", IMemAddr, IMemReq); end
  endtask

  task automatic test_stall();
    IMemAck  = 1'b1;
    IMemData = 32'h1000FFFF;
    cycle();
    IMemAck  = 1'b0;
    checks++; if (SignExtImm32 !== 32'hFFFFFFFF) begin failures++; $display("FAIL stall_imm: got %h expected ffffffff", SignExtImm32); end
    Stall    = 1'b1;
    ExecDone = 1'b1;
    NextPC   = 32'h00000020;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (CurrentPC !== 32'h90000400 || InstrValid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d: got pc=%h valid=%b expected 90000400/1", i, CurrentPC, InstrValid); end
    end
    Stall = 1'b0;
    cycle();
    ExecDone = 1'b0;
    checks++; if (CurrentPC !== 32'h20 || IMemReq !== 1'b1) begin failures++; $display("FAIL stall_release: got pc=%h req=%b expected 00000020/1", CurrentPC, IMemReq); end
  endtask

  task automatic test_timeout();
    IMemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (FetchFault !== 1'b0 || IMemReq !== 1'b1) begin failures++; $display("FAIL to_wait%0d: got fault=%b req=%b expected 0/1", i, FetchFault, IMemReq); end
    end
    cycle();
    checks++; if (FetchFault !== 1'b1 || IMemReq !== 1'b0) begin failures++; $display("FAIL to_fault: got fault=%b req=%b expected 1/0", FetchFault, IMemReq); end
    checks++; if (CurrentPC !== 32'h20) begin failures++; $display("FAIL to_pc: got %h expected 00000020", CurrentPC); end
    IMemAck  = 1'b1;
    IMemData = 32'h08000001;
    cycle();
    cycle();
    IMemAck = 1'b0;
    checks++; if (InstrValid !== 1'b0 || FetchFault !== 1'b1 || Instruction !== 32'h1000FFFF) begin failures++; $display("FAIL to_late_ack: got valid=%b fault=%b instr=%h expected 0/1/1000ffff", InstrValid, FetchFault, Instruction); end
    Reset = 1'b1;
    cycle();
    checks++; if (FetchFault !== 1'b0) begin failures++; $display("FAIL to_reset_clear: got %b expected 0", FetchFault); end
    Reset = 1'b0;
    cycle();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin failures++; $display("FAIL to_restart: got req=%b addr=%h expected 1/00000000", IMemReq, IMemAddr); end
  endtask

  task automatic test_misaligned();
    IMemAck  = 1'b1;
    IMemData = 32'h00000000;
    cycle();
    IMemAck  = 1'b0;
    ExecDone = 1'b1;
    NextPC   = 32'h00000006;
    cycle();
    ExecDone = 1'b0;
    checks++; if (CurrentPC !== 32'h6 || IMemReq !== 1'b0 || FetchFault !== 1'b0) begin failures++; $display("FAIL mis_entry: got pc=%h req=%b fault=%b expected 00000006/0/0", CurrentPC, IMemReq, FetchFault); end
    cycle();
    checks++; if (FetchFault !== 1'b1 || IMemReq !== 1'b0 || CurrentPC !== 32'h6) begin failures++; $display("FAIL mis_fault: got fault=%b req=%b pc=%h expected 1/0/00000006", FetchFault, IMemReq, CurrentPC); end
    cycle();
    checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin failures++; $display("FAIL mis_quiet: got req=%b valid=%b expected 0/0", IMemReq, InstrValid); end
  endtask

  task automatic test_reset_with_ack();
    doReset();
    // Move into ISSUE at a non-reset PC first so reset has something to undo.
    IMemAck  = 1'b1;
    IMemData = 32'h10000003;
    cycle();
    IMemAck  = 1'b0;
    ExecDone = 1'b1;
    NextPC   = 32'h00000040;
    cycle();
    ExecDone = 1'b0;
    checks++; if (IMemReq !== 1'b1 || CurrentPC !== 32'h40) begin failures++; $display("FAIL rst_ack_setup: got req=%b pc=%h expected 1/00000040", IMemReq, CurrentPC); end
    Reset    = 1'b1;
    IMemAck  = 1'b1;
    IMemData = 32'h08000100;
    ExecDone = 1'b1;
    cycle();
    Reset    = 1'b0;
    IMemAck  = 1'b0;
    ExecDone = 1'b0;
    checks++; if (Instruction !== 32'h0 || CurrentPC !== 32'h0 || InstrValid !== 1'b0 || IMemReq !== 1'b0) begin failures++; $display("FAIL rst_ack: got instr=%h pc=%h valid=%b req=%b expected 0/0/0/0", Instruction, CurrentPC, InstrValid, IMemReq); end
    cycle();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin failures++; $display("FAIL rst_ack_fetch: got req=%b addr=%h expected 1/00000000", IMemReq, IMemAddr); end
  endtask

  initial begin
    #1;
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_timeout();
    test_misaligned();
    test_reset_with_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential front end wrapped around the combinational next-PC logic.
- Holds the program counter and fetches from instruction memory over a req/ack handshake.
- Decodes the fetched word into the branch/jump control fields that the next-PC logic consumes: JumpField, SignExtImm32, Branch, Jump.
- Takes the resolved NextPC back from that logic and loads it into the PC when the datapath reports completion. This closes the loop on the opposite side of the next-PC interface.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- MAX_WAIT, 16, number of consecutive un-acked fetch cycles that trigger a fetch fault (range 1-255).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  32  fetch address; always equals CurrentPC.
- IMemAck  input  1  memory accepts the request and IMemData is valid this cycle.
- IMemData  input  32  instruction word, sampled only when IMemReq and IMemAck are both 1.
- NextPC  input  32  next PC from the next-PC logic; sampled on commit.
- ExecDone  input  1  datapath has resolved ALUZero and NextPC is valid.
- Stall  input  1  suppresses commit while high.
- CurrentPC  output  32  program counter register.
- Instruction  output  32  latched instruction register.
- InstrValid  output  1  Instruction and decoded fields are valid.
- JumpField  output  26  Instruction[25:0].
- SignExtImm32  output  32  sign-extended Instruction[15:0].
- Branch  output  1  1 when Instruction[31:26] == 6'b000100 (beq).
- Jump  output  1  1 when Instruction[31:26] == 6'b000010 (j).
- FetchFault  output  1  sticky fault flag.

Behaviour:
- Reset (any state, any cycle, including mid-handshake):
  - CurrentPC = RESET_PC, Instruction = 0, InstrValid = 0, IMemReq = 0, FetchFault = 0, wait counter = 0, state = FETCH.
  - Decoded outputs follow Instruction = 0: Branch = 0, Jump = 0, JumpField = 0, SignExtImm32 = 0.
- States: FETCH, ISSUE, FAULT.
- FETCH:
  - On entry, if CurrentPC[1:0] != 0, go to FAULT the next cycle with IMemReq = 0 (misaligned fault).
  - Otherwise IMemReq = 1 and IMemAddr = CurrentPC.
  - If IMemAck = 1: Instruction <= IMemData, counter <= 0, go to ISSUE.
  - Else counter += 1. When counter reaches MAX_WAIT-1 without an ack, go to FAULT.
  - Acks arriving while IMemReq = 0 are ignored.
- ISSUE:
  - IMemReq = 0, InstrValid = 1.
  - Decoded outputs are combinational from Instruction and stable for the whole state.
  - If ExecDone = 1 and Stall = 0: CurrentPC <= NextPC, go to FETCH; InstrValid drops the next cycle.
  - ExecDone while Stall = 1 is ignored; it must be re-asserted.
- FAULT:
  - FetchFault = 1, IMemReq = 0, InstrValid = 0.
  - CurrentPC holds the faulting address.
  - Only Reset exits this state.
- Latency:
  - The first request is 1 cycle after Reset deasserts.
  - A zero-wait ack gives InstrValid = 1 on the following cycle.
  - Minimum instruction period is 2 cycles (FETCH + ISSUE).
- Width rules:
  - SignExtImm32 = {{16{Instruction[15]}}, Instruction[15:0]}.
  - NextPC is taken unmodified, with no wrap checking; a PC of FFFFFFFC plus 4 wraps to 0 upstream.
- Simultaneous events: Reset overrides Ack, ExecDone and Stall.

Test Plan:
- Reset, then Ack with IMemData = 32'h10000003 on the first request:
  - IMemAddr = 0 while requesting.
  - Next cycle: InstrValid = 1, Branch = 1, Jump = 0, SignExtImm32 = 3.
  - ExecDone with NextPC = 32'h10 -> CurrentPC = 16; IMemReq reasserts the following cycle.
- Fetch IMemData = 32'h08000100 -> Jump = 1, JumpField = 26'h0000100. ExecDone with NextPC = 32'h90000400 -> IMemAddr = 32'h90000400.
- IMemData = 32'h1000FFFF -> SignExtImm32 = 32'hFFFFFFFF. Hold Stall = 1 with ExecDone pulsed for 3 cycles -> CurrentPC unchanged and InstrValid stays 1. Release Stall with ExecDone -> commit.
- Withhold IMemAck with MAX_WAIT = 4 -> FetchFault = 1 after 4 request cycles, IMemReq = 0, and a late ack is ignored. Reset clears the fault and the next request is at RESET_PC.
- Commit NextPC = 32'h00000006 -> FAULT is entered without any request being issued; CurrentPC = 6.
- Assert Reset in the same cycle as IMemAck -> Instruction = 0, CurrentPC = RESET_PC, state = FETCH.
